// File: rtl/spi_slave_pkg.sv
// ---------------------------------------------------------------------------
// spi_slave_pkg
// Shared definitions for the SPI slave receive path.
//   DEF_FRAME_W / DEF_CMD_W : default frame and command-field widths
//   rx_state_t              : receive FSM states
//   CMD_*                   : command encodings found in the top bits of a frame
// ---------------------------------------------------------------------------
package spi_slave_pkg;

   localparam int DEF_FRAME_W = 10;
   localparam int DEF_CMD_W   = 2;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      CHK_CMD   = 3'd1,
      WRITE     = 3'd2,
      READ_ADD  = 3'd3,
      READ_DATA = 3'd4,
      DONE      = 3'd5
   } rx_state_t;

   localparam logic [DEF_CMD_W-1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [DEF_CMD_W-1:0] CMD_WR_DATA = 2'b01;
   localparam logic [DEF_CMD_W-1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [DEF_CMD_W-1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave_rx_fsm_shifter.sv
// ---------------------------------------------------------------------------
// spi_rx_shifter
// MSB-first shift register with a saturating bit counter.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   clear       : zero the shift register and counter (takes priority)
//   shift_en    : shift din into the LSB and count one bit (ignored when full)
//   din         : serial data in
//   frame_next  : value the register would hold after shifting din in now
//   last        : exactly FRAME_W-1 bits held, so the next shift completes a frame
//   full        : FRAME_W bits held
// ---------------------------------------------------------------------------
module spi_rx_shifter #(
   parameter int FRAME_W = 10,
   parameter int CNT_W   = $clog2(FRAME_W + 1)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               clear,
   input  logic               shift_en,
   input  logic               din,
   output logic [FRAME_W-1:0] frame_next,
   output logic               last,
   output logic               full
);

   logic [FRAME_W-1:0] sr;
   logic [CNT_W-1:0]   cnt;

   assign frame_next = {sr[FRAME_W-2:0], din};
   assign last       = (cnt == CNT_W'(FRAME_W - 1));
   assign full       = (cnt == CNT_W'(FRAME_W));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sr  <= '0;
         cnt <= '0;
      end else if (clear) begin
         sr  <= '0;
         cnt <= '0;
      end else if (shift_en && !full) begin
         // Saturating: the counter can never pass FRAME_W.
         sr  <= frame_next;
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/spi_slave_rx_fsm.sv
// ---------------------------------------------------------------------------
// spi_slave_rx_fsm
// Receive side of the SPI slave: deserializes MOSI into {cmd, payload} frames,
// tracks the write / read-address / read-data command sequence and hands each
// legal frame to the RAM interface.
// Ports:
//   clk, rst     : SPI clock (rising edge), asynchronous active-high reset
//   ss_n, mosi   : slave select (active low), serial data in
//   rx_data      : last accepted frame {cmd, payload}
//   rx_valid     : one-cycle pulse, rx_data updated
//   rd_pending   : read address accepted, read-data frame outstanding
//   frame_err    : one-cycle pulse, command illegal for the current read phase
//   frame_abort  : one-cycle pulse, ss_n rose mid-frame
// Handshake: rx_valid is a pure strobe with no ready; the consumer must take
// rx_data in the cycle rx_valid is high (rx_data is held afterwards anyway).
// ---------------------------------------------------------------------------
import spi_slave_pkg::*;

module spi_slave_rx_fsm #(
   parameter int FRAME_W = DEF_FRAME_W,
   parameter int CMD_W   = DEF_CMD_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               ss_n,
   input  logic               mosi,
   output logic [FRAME_W-1:0] rx_data,
   output logic               rx_valid,
   output logic               rd_pending,
   output logic               frame_err,
   output logic               frame_abort
);

   rx_state_t          state, state_n;
   logic               shift_en, clear;
   logic [FRAME_W-1:0] frame_next;
   logic               last, full;
   logic [CMD_W-1:0]   cmd;
   logic               legal;

   logic [FRAME_W-1:0] rx_data_n;
   logic               rx_valid_n, rd_pending_n, frame_err_n, frame_abort_n;

   spi_rx_shifter #(.FRAME_W(FRAME_W)) u_shifter (
      .clk        (clk),
      .rst        (rst),
      .clear      (clear),
      .shift_en   (shift_en),
      .din        (mosi),
      .frame_next (frame_next),
      .last       (last),
      .full       (full)
   );

   // Command field of the frame as it stands once the current bit is in.
   assign cmd = frame_next[FRAME_W-1 -: CMD_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         rd_pending  <= 1'b0;
         frame_err   <= 1'b0;
         frame_abort <= 1'b0;
      end else begin
         state       <= state_n;
         rx_data     <= rx_data_n;
         rx_valid    <= rx_valid_n;
         rd_pending  <= rd_pending_n;
         frame_err   <= frame_err_n;
         frame_abort <= frame_abort_n;
      end
   end

   always_comb begin
      state_n       = state;
      shift_en      = 1'b0;
      clear         = 1'b0;
      legal         = 1'b0;
      rx_data_n     = rx_data;
      rx_valid_n    = 1'b0;
      rd_pending_n  = rd_pending;
      frame_err_n   = 1'b0;
      frame_abort_n = 1'b0;

      case (state)
         IDLE: begin
            // Idle edge after ss_n falls: mosi is not sampled, shifter starts empty.
            clear = 1'b1;
            if (!ss_n) state_n = CHK_CMD;
         end

         CHK_CMD: begin
            if (ss_n) begin
               clear         = 1'b1;
               frame_abort_n = 1'b1;
               state_n       = IDLE;
            end else begin
               shift_en = 1'b1;
               // The first command bit picks the phase; read phase follows rd_pending.
               if (!mosi)          state_n = WRITE;
               else if (rd_pending) state_n = READ_DATA;
               else                state_n = READ_ADD;
            end
         end

         WRITE, READ_ADD, READ_DATA: begin
            if (ss_n) begin
               clear         = 1'b1;
               frame_abort_n = 1'b1;
               state_n       = IDLE;
            end else begin
               shift_en = !full;
               if (last) begin
                  // Final bit: judge the complete frame on this same edge.
                  state_n = DONE;
                  case (state)
                     READ_ADD:  legal = (cmd == CMD_RD_ADDR);
                     READ_DATA: legal = (cmd == CMD_RD_DATA);
                     default:   legal = 1'b1;
                  endcase
                  if (legal) begin
                     rx_data_n  = frame_next;
                     rx_valid_n = 1'b1;
                     if (state == READ_ADD)  rd_pending_n = 1'b1;
                     if (state == READ_DATA) rd_pending_n = 1'b0;
                  end else begin
                     frame_err_n = 1'b1;
                  end
               end
            end
         end

         DONE: begin
            // Overrun bits are dropped until the master releases ss_n.
            if (ss_n) state_n = IDLE;
         end

         default: begin
            clear   = 1'b1;
            state_n = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_spi_slave_rx_fsm.sv
module tb_spi_slave_rx_fsm;

   localparam int FW = 10;

   logic          clk = 1'b0;
   logic          rst;
   logic          ss_n;
   logic          mosi;
   logic [FW-1:0] rx_data;
   logic          rx_valid;
   logic          rd_pending;
   logic          frame_err;
   logic          frame_abort;

   spi_slave_rx_fsm dut (
      .clk         (clk),
      .rst         (rst),
      .ss_n        (ss_n),
      .mosi        (mosi),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rd_pending  (rd_pending),
      .frame_err   (frame_err),
      .frame_abort (frame_abort)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state: what the slave should be holding at frame level.
   logic [FW-1:0] exp_data;
   logic          exp_rd;

   // Per-frame observations.
   int n_v, n_e, n_a, n_multi, pstep;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic observe(input int step);
      int k;
      k = int'(rx_valid) + int'(frame_err) + int'(frame_abort);
      if (k > 0 && pstep < 0) pstep = step;
      if (k > 1) n_multi++;
      n_v += int'(rx_valid);
      n_e += int'(frame_err);
      n_a += int'(frame_abort);
   endtask

   // Drive one ss_n window: idle edge, nbits frame bits MSB first, hold extra
   // overrun bits, then release ss_n for two edges. Checks against the model.
   task automatic run_frame(input string tag, input logic [FW-1:0] f,
                            input int nbits, input int hold);
      int  step;
      int  e_v, e_e, e_a, e_step;
      logic [1:0] c, want;
      logic legal;
      n_v = 0; n_e = 0; n_a = 0; n_multi = 0; pstep = -1;
      step = 0;
      @(negedge clk); ss_n = 1'b0; mosi = 1'($urandom);
      @(posedge clk); #1 observe(step);
      for (int i = 0; i < nbits; i++) begin
         step++;
         @(negedge clk); mosi = f[FW-1-i];
         @(posedge clk); #1 observe(step);
      end
      for (int i = 0; i < hold; i++) begin
         step++;
         @(negedge clk); mosi = 1'($urandom);
         @(posedge clk); #1 observe(step);
      end
      step++;
      @(negedge clk); ss_n = 1'b1; mosi = 1'($urandom);
      @(posedge clk); #1 observe(step);
      step++;
      @(posedge clk); #1 observe(step);

      // Frame-level model.
      if (nbits == FW) begin
         c = f[FW-1 -: 2];
         if (c[1] == 1'b0) legal = 1'b1;
         else begin
            want  = exp_rd ? 2'b11 : 2'b10;
            legal = (c == want);
         end
         e_v = legal ? 1 : 0;
         e_e = legal ? 0 : 1;
         e_a = 0;
         e_step = FW;
         if (legal) begin
            exp_data = f;
            if (c == 2'b10) exp_rd = 1'b1;
            if (c == 2'b11) exp_rd = 1'b0;
         end
      end else begin
         e_v = 0; e_e = 0; e_a = 1;
         e_step = nbits + 1;
      end

      check({tag, " rx_valid_pulses"},    n_v,        e_v);
      check({tag, " frame_err_pulses"},   n_e,        e_e);
      check({tag, " frame_abort_pulses"}, n_a,        e_a);
      check({tag, " pulse_overlap"},      n_multi,    0);
      check({tag, " pulse_cycle"},        pstep,      e_step);
      check({tag, " rx_data"},            rx_data,    exp_data);
      check({tag, " rd_pending"},         rd_pending, exp_rd);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, " rx_data"},     rx_data,     0);
      check({tag, " rx_valid"},    rx_valid,    0);
      check({tag, " rd_pending"},  rd_pending,  0);
      check({tag, " frame_err"},   frame_err,   0);
      check({tag, " frame_abort"}, frame_abort, 0);
   endtask

   initial begin
      logic [FW-1:0] f;
      int nb, hd;
      rst = 1'b1; ss_n = 1'b1; mosi = 1'b0;
      exp_data = '0; exp_rd = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;

      // Put state into the DUT so the mid-frame reset has something to clear.
      run_frame("pre_rd_addr", 10'h2AB, FW, 0);

      // Reset after 4 bits of a frame.
      @(negedge clk); ss_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk); mosi = 1'($urandom);
      end
      @(negedge clk); rst = 1'b1; ss_n = 1'b1;
      #1 check_all_zero("mid_reset");
      exp_data = '0; exp_rd = 1'b0;
      @(negedge clk); rst = 1'b0;
      run_frame("post_reset", 10'h0A5, FW, 0);

      // Write pair.
      run_frame("wr_addr", 10'h007, FW, 0);
      run_frame("wr_data", 10'h1C3, FW, 0);

      // Read sequence.
      run_frame("rd_addr", 10'h210, FW, 0);
      run_frame("rd_data", 10'h300, FW, 0);

      // Illegal reads.
      run_frame("ill_rd_data", 10'h3FF, FW, 0);
      run_frame("rd_addr2",    10'h210, FW, 0);
      run_frame("ill_rd_addr", 10'h2AA, FW, 0);
      run_frame("rd_data2",    10'h3C3, FW, 0);

      // Abort after 5 bits, then a clean frame; abort right at the command bit.
      run_frame("abort5",      10'h1FF, 5, 0);
      run_frame("after_abort", 10'h055, FW, 0);
      run_frame("abort0",      10'h3FF, 0, 0);
      run_frame("abort9",      10'h000, FW-1, 0);

      // Overrun: 14 bit clocks with ss_n low.
      run_frame("overrun", 10'h0F0, FW, 4);

      // Randomized frames.
      for (int n = 0; n < 60; n++) begin
         f  = FW'($urandom);
         nb = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, FW-1)) : FW;
         hd = (nb == FW) ? int'($urandom_range(0, 3)) : 0;
         run_frame($sformatf("rand%0d", n), f, nb, hd);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
